// File: rtl/semaforo_ctrl.sv
// Traffic-light controller with pedestrian request; phases are timed in ticks
// derived from the divider's slow clock (novo_clock) after synchronisation.
module semaforo_ctrl #(
    parameter int T_VERDE     = 10,
    parameter int T_MIN_VERDE = 4,
    parameter int T_AMARELO   = 3,
    parameter int T_VERMELHO  = 8,
    parameter int T_LIMPEZA   = 1,
    parameter int CNT_W       = 5
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             novo_clock,
    input  logic             pedido,
    output logic [2:0]       luz_carro,
    output logic [1:0]       luz_pedestre,
    output logic [1:0]       estado,
    output logic [CNT_W-1:0] restante,
    output logic             pedido_pendente
);

    typedef enum logic [1:0] {
        VERDE    = 2'd0,
        AMARELO  = 2'd1,
        VERMELHO = 2'd2,
        LIMPEZA  = 2'd3
    } estado_t;

    localparam int MAX_DUR = (1 << CNT_W) - 1;
    localparam bit PARAM_OK = (T_VERDE >= 1) && (T_VERDE <= MAX_DUR) &&
                              (T_AMARELO >= 1) && (T_AMARELO <= MAX_DUR) &&
                              (T_VERMELHO >= 1) && (T_VERMELHO <= MAX_DUR) &&
                              (T_LIMPEZA >= 1) && (T_LIMPEZA <= MAX_DUR) &&
                              (T_MIN_VERDE >= 1) && (T_MIN_VERDE <= T_VERDE);

    localparam logic [CNT_W-1:0] L_VERDE    = CNT_W'(T_VERDE);
    localparam logic [CNT_W-1:0] L_AMARELO  = CNT_W'(T_AMARELO);
    localparam logic [CNT_W-1:0] L_VERMELHO = CNT_W'(T_VERMELHO);
    localparam logic [CNT_W-1:0] L_LIMPEZA  = CNT_W'(T_LIMPEZA);
    // Green may be cut once T_MIN_VERDE ticks have elapsed in it
    localparam logic [CNT_W-1:0] L_CORTE    = CNT_W'(T_VERDE - T_MIN_VERDE + 1);

    logic             r_nc_s1, r_nc_s2, r_nc_s3;
    logic             r_pd_s1, r_pd_s2;
    estado_t          r_estado, w_estado_prox;
    logic [CNT_W-1:0] r_restante, w_restante_prox;
    logic             r_pendente, w_pendente_prox;
    logic             w_tick, w_sai;

    always_ff @(posedge clock_50) begin
        assert (PARAM_OK) else $error("semaforo_ctrl: illegal phase duration parameters");
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_nc_s1 <= 1'b0;
            r_nc_s2 <= 1'b0;
            r_nc_s3 <= 1'b0;
            r_pd_s1 <= 1'b0;
            r_pd_s2 <= 1'b0;
        end else begin
            r_nc_s1 <= novo_clock;
            r_nc_s2 <= r_nc_s1;
            r_nc_s3 <= r_nc_s2;
            r_pd_s1 <= pedido;
            r_pd_s2 <= r_pd_s1;
        end
    end

    assign w_tick = r_nc_s2 & ~r_nc_s3;

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_estado   <= VERDE;
            r_restante <= L_VERDE;
            r_pendente <= 1'b0;
        end else begin
            r_estado   <= w_estado_prox;
            r_restante <= w_restante_prox;
            r_pendente <= w_pendente_prox;
        end
    end

    always_comb begin
        w_estado_prox   = r_estado;
        w_restante_prox = r_restante;
        w_pendente_prox = r_pendente;
        w_sai           = 1'b0;

        if (w_tick) begin
            w_sai = (r_restante == CNT_W'(1)) ||
                    ((r_estado == VERDE) && r_pendente && (r_restante <= L_CORTE));
            if (w_sai) begin
                unique case (r_estado)
                    VERDE:    begin w_estado_prox = AMARELO;  w_restante_prox = L_AMARELO;  end
                    AMARELO:  begin w_estado_prox = VERMELHO; w_restante_prox = L_VERMELHO; end
                    VERMELHO: begin w_estado_prox = LIMPEZA;  w_restante_prox = L_LIMPEZA;  end
                    LIMPEZA:  begin w_estado_prox = VERDE;    w_restante_prox = L_VERDE;    end
                endcase
            end else begin
                w_restante_prox = r_restante - CNT_W'(1);
            end
        end

        // Entering VERMELHO serves the request; the clear overrides a same-cycle set
        if (r_pd_s2 && (r_estado != VERMELHO))
            w_pendente_prox = 1'b1;
        if (w_sai && (r_estado == AMARELO))
            w_pendente_prox = 1'b0;
    end

    always_comb begin
        luz_carro    = 3'b001;
        luz_pedestre = 2'b01;
        unique case (r_estado)
            VERDE:    begin luz_carro = 3'b001; luz_pedestre = 2'b01; end
            AMARELO:  begin luz_carro = 3'b010; luz_pedestre = 2'b01; end
            VERMELHO: begin luz_carro = 3'b100; luz_pedestre = 2'b10; end
            LIMPEZA:  begin luz_carro = 3'b100; luz_pedestre = 2'b01; end
        endcase
    end

    assign estado          = r_estado;
    assign restante        = r_restante;
    assign pedido_pendente = r_pendente;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl: full cycle, pedestrian requests, async
// reset mid-phase and long-held novo_clock.
module tb_semaforo_ctrl;

    logic       clock_50 = 1'b0;
    logic       reset = 1'b1;
    logic       novo_clock = 1'b0;
    logic       pedido = 1'b0;
    logic [2:0] luz_carro;
    logic [1:0] luz_pedestre;
    logic [1:0] estado;
    logic [4:0] restante;
    logic       pedido_pendente;

    int n_cmp = 0;
    int n_err = 0;

    semaforo_ctrl dut (
        .clock_50        (clock_50),
        .reset           (reset),
        .novo_clock      (novo_clock),
        .pedido          (pedido),
        .luz_carro       (luz_carro),
        .luz_pedestre    (luz_pedestre),
        .estado          (estado),
        .restante        (restante),
        .pedido_pendente (pedido_pendente)
    );

    always #10 clock_50 = ~clock_50;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One novo_clock period of 10 clock_50 cycles; state updates 3 edges after the rise
    task automatic tick();
        novo_clock = 1'b1;
        repeat (5) @(negedge clock_50);
        novo_clock = 1'b0;
        repeat (5) @(negedge clock_50);
    endtask

    task automatic chk_fase(input string tag, input int est, input int rest);
        chk({tag, " estado"}, estado, est);
        chk({tag, " restante"}, restante, rest);
    endtask

    // Phase tables: duration, car lights, pedestrian lights per estado code
    int dur   [4] = '{10, 3, 8, 1};
    int carro [4] = '{1, 2, 4, 4};
    int pedes [4] = '{1, 1, 2, 1};

    initial begin
        // Reset state
        repeat (5) @(negedge clock_50);
        chk_fase("reset", 0, 10);
        chk("reset luz_carro", luz_carro, 1);
        chk("reset luz_pedestre", luz_pedestre, 1);
        chk("reset pendente", pedido_pendente, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock_50);
        chk_fase("pos-reset sem tick", 0, 10);

        // 1: full unrequested cycle, 22 ticks
        for (int p = 0; p < 4; p++) begin
            chk_fase("ciclo entrada", p, dur[p]);
            chk("ciclo luz_carro", luz_carro, carro[p]);
            chk("ciclo luz_pedestre", luz_pedestre, pedes[p]);
            for (int i = 1; i < dur[p]; i++) begin
                tick();
                chk_fase("ciclo decremento", p, dur[p] - i);
                chk("ciclo luz_carro meio", luz_carro, carro[p]);
            end
            tick();
        end
        chk_fase("ciclo volta", 0, 10);

        // 2: pulse right after VERDE entry
        pedido = 1'b1;
        @(negedge clock_50);
        pedido = 1'b0;
        @(negedge clock_50);
        chk("pulso pendente cedo", pedido_pendente, 0);
        @(negedge clock_50);
        chk("pulso pendente", pedido_pendente, 1);
        tick(); chk_fase("pulso t1", 0, 9);
        tick(); chk_fase("pulso t2", 0, 8);
        tick(); chk_fase("pulso t3", 0, 7);
        tick(); chk_fase("pulso t4 corta", 1, 3);
        chk("pulso pendente amarelo", pedido_pendente, 1);
        repeat (3) tick();
        chk_fase("pulso vermelho", 2, 8);
        chk("pulso pendente limpo", pedido_pendente, 0);

        // 4: pedido held through VERMELHO
        pedido = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("vermelho ignora pedido", pedido_pendente, 0);
        end
        tick();
        chk_fase("retido limpeza", 3, 1);
        chk("retido pendente limpeza", pedido_pendente, 1);
        pedido = 1'b0;
        tick();
        chk_fase("retido verde", 0, 10);
        repeat (3) tick();
        chk_fase("retido verde t3", 0, 7);
        tick();
        chk_fase("retido verde 4 ticks", 1, 3);
        repeat (3) tick();
        chk("retido pendente vermelho", pedido_pendente, 0);
        repeat (9) tick();
        chk_fase("retido nova verde", 0, 10);
        chk("retido sem pendente", pedido_pendente, 0);

        // 3: request when restante=3 in VERDE
        repeat (7) tick();
        chk_fase("tardio restante 3", 0, 3);
        pedido = 1'b1;
        @(negedge clock_50);
        pedido = 1'b0;
        repeat (2) @(negedge clock_50);
        chk("tardio pendente", pedido_pendente, 1);
        chk_fase("tardio ainda verde", 0, 3);
        tick();
        chk_fase("tardio amarelo", 1, 3);

        // 5: async reset between edges mid-AMARELO
        tick();
        chk_fase("pre-reset amarelo", 1, 2);
        @(posedge clock_50);
        #3 reset = 1'b1;
        #2;
        chk_fase("reset async", 0, 10);
        chk("reset async luz_carro", luz_carro, 1);
        chk("reset async luz_pedestre", luz_pedestre, 1);
        chk("reset async pendente", pedido_pendente, 0);
        #2 reset = 1'b0;
        @(negedge clock_50);

        // 6: novo_clock held high 100 cycles, then toggled
        novo_clock = 1'b1;
        repeat (2) @(negedge clock_50);
        chk_fase("alto 2 bordas", 0, 10);
        @(negedge clock_50);
        chk_fase("alto 3 bordas", 0, 9);
        repeat (97) @(negedge clock_50);
        chk_fase("alto mantido", 0, 9);
        novo_clock = 1'b0;
        repeat (5) @(negedge clock_50);
        novo_clock = 1'b1;
        repeat (2) @(negedge clock_50);
        chk_fase("subida 2 bordas", 0, 9);
        @(negedge clock_50);
        chk_fase("subida 3 bordas", 0, 8);
        repeat (7) @(negedge clock_50);
        novo_clock = 1'b0;
        repeat (5) @(negedge clock_50);
        chk_fase("subida unica", 0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
